// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that picks one of NREQ result producers, latches its word
// and shifts it out MSB-first as a framed serial stream (sof/eof, source id).
module serial_tx_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 75,
    parameter int IDW   = 2,
    parameter int GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  tx_en,
    output logic                  sdout,
    output logic                  sdout_valid,
    output logic                  sof,
    output logic                  eof,
    output logic [IDW-1:0]        tx_id,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    localparam int BCW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               sdout_q, sdout_d;
    logic               sdout_valid_q, sdout_valid_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
    logic [IDW-1:0]     tx_id_q, tx_id_d;
    logic               frame_done_q, frame_done_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               win_vld;
    logic [IDW-1:0]     win_idx;
    logic               grant;

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_vld && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                win_vld = 1'b1;
                win_idx = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // rst_n gating keeps req_ready low while reset is held, independent of inputs.
    assign grant     = rst_n && tx_en && win_vld && (state_q == ST_IDLE);
    assign req_ready = grant ? (NREQ'(1) << win_idx) : '0;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        gap_cnt_d     = gap_cnt_q;
        sdout_d       = sdout_q;
        tx_id_d       = tx_id_q;
        frame_cnt_d   = frame_cnt_q;
        sdout_valid_d = 1'b0;
        sof_d         = 1'b0;
        eof_d         = 1'b0;
        frame_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    shreg_d   = req_data[int'(win_idx)*WIDTH +: WIDTH];
                    tx_id_d   = win_idx;
                    ptr_d     = win_idx;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tx_en) begin
                    sdout_d       = shreg_q[WIDTH-1];
                    shreg_d       = shreg_q << 1;
                    sdout_valid_d = 1'b1;
                    sof_d         = (bit_cnt_q == '0);
                    eof_d         = (bit_cnt_q == BCW'(WIDTH - 1));
                    bit_cnt_d     = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BCW'(WIDTH - 1)) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        gap_cnt_d    = '0;
                        state_d      = (GAP > 0) ? ST_GAP : ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == 4'(GAP - 1))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= IDW'(NREQ - 1);
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            gap_cnt_q     <= '0;
            sdout_q       <= 1'b0;
            sdout_valid_q <= 1'b0;
            sof_q         <= 1'b0;
            eof_q         <= 1'b0;
            tx_id_q       <= '0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            gap_cnt_q     <= gap_cnt_d;
            sdout_q       <= sdout_d;
            sdout_valid_q <= sdout_valid_d;
            sof_q         <= sof_d;
            eof_q         <= eof_d;
            tx_id_q       <= tx_id_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign sdout       = sdout_q;
    assign sdout_valid = sdout_valid_q;
    assign sof         = sof_q;
    assign eof         = eof_q;
    assign tx_id       = tx_id_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: framing, round-robin order, pause, reset.
module tb_serial_tx_arbiter;
    localparam int NREQ = 4, WIDTH = 75, IDW = 2, GAP = 1;

    logic                  clk, rst_n, tx_en;
    logic [NREQ-1:0]       req_valid, req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  sdout, sdout_valid, sof, eof, busy, frame_done;
    logic [IDW-1:0]        tx_id;
    logic [15:0]           frame_cnt;
    logic [WIDTH-1:0]      dat [NREQ];

    int n_vec = 0, n_err = 0, cyc = 0;

    serial_tx_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_en(tx_en), .sdout(sdout), .sdout_valid(sdout_valid),
        .sof(sof), .eof(eof), .tx_id(tx_id), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dat[i];
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx_en = 1'b0; req_valid = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits (bounded) for a grant, then steps through the handshake edge.
    task automatic wait_grant(input string tag, output int who, output int t);
        who = -1; t = 0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (req_ready != '0) begin
                chk({tag, "_onehot"}, WIDTH'($onehot(req_ready)), 1);
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) who = i;
                t = cyc;
                tick();
                return;
            end
            @(negedge clk);
        end
        chk({tag, "_grant_timeout"}, 0, 1);
    endtask

    // Collects one frame starting right after the handshake edge; optional tx_en pause.
    task automatic collect(input string tag, input int pause_at, input int pause_len,
                           output logic [WIDTH-1:0] word, output int nvalid, output int ncyc,
                           output bit sof_ok, output bit hold_ok, output bit fd,
                           output logic [15:0] fcnt);
        int c;
        logic held;
        word = '0; nvalid = 0; ncyc = 0; sof_ok = 1'b0; hold_ok = 1'b1; fd = 1'b0; fcnt = '0;
        c = 0;
        while (c < 400) begin
            tick(); c++;
            if (sdout_valid) begin
                if (nvalid == 0) sof_ok = sof;
                else if (sof) sof_ok = 1'b0;
                word = {word[WIDTH-2:0], sdout};
                nvalid++;
                if (eof) begin
                    ncyc = c; fd = frame_done; fcnt = frame_cnt;
                    return;
                end
                if (nvalid == pause_at && pause_len > 0) begin
                    held = sdout; tx_en = 1'b0;
                    for (int p = 0; p < pause_len; p++) begin
                        tick(); c++;
                        if (sdout_valid || sdout !== held) hold_ok = 1'b0;
                    end
                    tx_en = 1'b1;
                end
            end
        end
        chk({tag, "_eof_timeout"}, 0, 1);
    endtask

    initial begin
        int who, t, tprev, nv, nc;
        bit sok, hok, fd, ok;
        logic [WIDTH-1:0] w;
        logic [15:0] fc;
        int exp_order [5];

        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) dat[i] = '0;
        rst_n = 1'b1; tx_en = 1'b1; req_valid = 4'b1111;
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", WIDTH'({sdout, sdout_valid, sof, eof, tx_id, busy,
                                       frame_done, frame_cnt, req_ready}), 0);
        do_reset();

        // Single request
        dat[0] = 75'h400_0000_0000_0000_0001;
        tx_en = 1'b1; req_valid = 4'b0001;
        #1 chk("t1_ready", WIDTH'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        chk("t1_ready_drop", WIDTH'(req_ready), 0);
        chk("t1_busy", WIDTH'(busy), 1);
        collect("t1", 0, 0, w, nv, nc, sok, hok, fd, fc);
        chk("t1_word", w, dat[0]);
        chk("t1_nvalid", WIDTH'(nv), 75);
        chk("t1_sof", WIDTH'(sok), 1);
        chk("t1_eof_lat", WIDTH'(nc), 75);
        chk("t1_frame_done", WIDTH'(fd), 1);
        chk("t1_frame_cnt", WIDTH'(fc), 1);
        chk("t1_tx_id", WIDTH'(tx_id), 0);
        tick();
        chk("t1_after", WIDTH'({sdout_valid, frame_done}), 0);

        // All four requesters continuously valid
        do_reset();
        dat[0] = 75'h123_4567_89AB_CDEF_0123;
        dat[1] = 75'h7ED_CBA9_8765_4321_0FED;
        dat[2] = 75'h0AA_5555_AAAA_5555_AAAA;
        dat[3] = 75'h555_0F0F_F0F0_1234_8000;
        tx_en = 1'b1; req_valid = 4'b1111;
        tprev = 0;
        for (int f = 0; f < 5; f++) begin
            wait_grant("t2", who, t);
            chk($sformatf("t2_order%0d", f), WIDTH'(who), WIDTH'(exp_order[f]));
            chk($sformatf("t2_tx_id%0d", f), WIDTH'(tx_id), WIDTH'(exp_order[f]));
            if (f > 0) chk($sformatf("t2_period%0d", f), WIDTH'(t - tprev), 77);
            tprev = t;
            collect("t2", 0, 0, w, nv, nc, sok, hok, fd, fc);
            chk($sformatf("t2_word%0d", f), w, dat[exp_order[f]]);
            chk($sformatf("t2_nvalid%0d", f), WIDTH'(nv), 75);
        end
        chk("t2_frame_cnt", WIDTH'(fc), 5);

        // Round-robin from requester 2
        do_reset();
        req_valid = 4'b0100; tx_en = 1'b1;
        wait_grant("t3a", who, t);
        chk("t3_first", WIDTH'(who), 2);
        req_valid = 4'b1100;
        collect("t3a", 0, 0, w, nv, nc, sok, hok, fd, fc);
        wait_grant("t3b", who, t);
        chk("t3_second", WIDTH'(who), 3);
        collect("t3b", 0, 0, w, nv, nc, sok, hok, fd, fc);
        wait_grant("t3c", who, t);
        chk("t3_third", WIDTH'(who), 2);
        req_valid = '0;
        collect("t3c", 0, 0, w, nv, nc, sok, hok, fd, fc);

        // Pause for 10 cycles after bit 30
        do_reset();
        dat[0] = 75'h5A5_1234_5678_9ABC_DEF0;
        req_valid = 4'b0001; tx_en = 1'b1;
        wait_grant("t4", who, t);
        req_valid = '0;
        collect("t4", 31, 10, w, nv, nc, sok, hok, fd, fc);
        chk("t4_word", w, dat[0]);
        chk("t4_nvalid", WIDTH'(nv), 75);
        chk("t4_hold", WIDTH'(hok), 1);
        chk("t4_eof_lat", WIDTH'(nc), 85);

        // Reset mid-frame at bit 40
        tick(); tick();
        dat[3] = '1;
        req_valid = 4'b1000;
        wait_grant("t5", who, t);
        chk("t5_who", WIDTH'(who), 3);
        for (int b = 0; b < 41; b++) tick();
        chk("t5_pre", WIDTH'({sdout_valid, sdout, tx_id, frame_cnt}), WIDTH'({1'b1, 1'b1, 2'd3, 16'd1}));
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1 chk("t5_async_reset", WIDTH'({sdout, sdout_valid, sof, eof, tx_id, busy,
                                        frame_done, frame_cnt, req_ready}), 0);
        tick();
        rst_n = 1'b1;
        req_valid = 4'b1010;
        wait_grant("t5b", who, t);
        chk("t5_ptr_reset", WIDTH'(who), 1);
        req_valid = '0;
        collect("t5b", 0, 0, w, nv, nc, sok, hok, fd, fc);
        chk("t5_frame_cnt", WIDTH'(fc), 1);

        // IDLE with tx_en low
        do_reset();
        tx_en = 1'b0; req_valid = 4'b1111;
        ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 if (req_ready != '0 || busy) ok = 1'b0;
            @(negedge clk);
        end
        chk("t6_no_grant", WIDTH'(ok), 1);
        tx_en = 1'b1;
        wait_grant("t6", who, t);
        chk("t6_who", WIDTH'(who), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
